// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forwarding and load-use hazard unit.
// A shadow pipeline records every in-flight write destination from EX
// (entry 0) to WB (entry DEPTH-1). It drives per-operand forwarding
// selects for the EX stage, raises load-use stalls for ID and keeps a
// saturating count of stall cycles.
// fwd_sel and id_stall are combinational decodes of registered state
// (and, for id_stall, of the ID-stage inputs) so that they apply in the
// same cycle the consumer is in EX or ID.
module fwd_scoreboard #(
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned SEL_W    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0]         id_rd,
    input  logic                        id_wr,
    input  logic                        id_load,
    input  logic                        pipe_hold,
    input  logic                        flush_ex,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        id_stall,
    output logic [15:0]                 stall_cnt
);

    localparam int unsigned CNT_W = 16;

    // Shadow pipeline state, one slot per tracked stage.
    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH-1:0]    ent_wr;
    logic [DEPTH-1:0]    ent_load;
    logic [REG_BITS-1:0] ent_rd [DEPTH];
    logic [REG_BITS-1:0] ex_rs  [NUM_SRC];

    logic admit_c;
    logic found_c;

    // A real instruction enters EX only when it is neither stalled nor killed.
    assign admit_c = id_valid && !id_stall && !flush_ex;

    // Shift the shadow pipeline on every non-held edge; bubbles carry zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_wr    <= '0;
            ent_load  <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                ent_rd[j] <= '0;
            end
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                ex_rs[k] <= '0;
            end
        end else if (!pipe_hold) begin
            for (int unsigned j = 1; j < DEPTH; j++) begin
                ent_valid[j] <= ent_valid[j-1];
                ent_wr[j]    <= ent_wr[j-1];
                ent_load[j]  <= ent_load[j-1];
                ent_rd[j]    <= ent_rd[j-1];
            end
            ent_valid[0] <= admit_c;
            ent_wr[0]    <= admit_c && id_wr;
            ent_load[0]  <= admit_c && id_load;
            ent_rd[0]    <= admit_c ? id_rd : '0;
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                ex_rs[k] <= admit_c ? id_rs[k*REG_BITS +: REG_BITS] : '0;
            end
        end
    end

    // Nearest qualifying producer per EX operand; loads only once forwardable.
    always_comb begin
        fwd_sel = '0;
        found_c = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            found_c = 1'b0;
            for (int unsigned j = 1; j < DEPTH; j++) begin
                if (!found_c && ent_valid[j] && ent_wr[j] &&
                    (ent_rd[j] == ex_rs[k]) && (ent_rd[j] != '0) &&
                    (!ent_load[j] || (j >= LOAD_LAT))) begin
                    fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(j);
                    found_c = 1'b1;
                end
            end
        end
    end

    // Stall ID while a load it depends on cannot reach a forwardable entry in time.
    always_comb begin
        id_stall = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (ent_valid[j] && ent_wr[j] && ent_load[j] &&
                    (ent_rd[j] == id_rs[k*REG_BITS +: REG_BITS]) &&
                    (ent_rd[j] != '0) && ((j + 1) < LOAD_LAT)) begin
                    id_stall = 1'b1;
                end
            end
        end
        id_stall = id_stall && id_valid;
    end

    // Saturating count of stall cycles that actually took effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pipe_hold && id_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
